// File: rtl/cla4_serial_ctrl.sv
// Serial WIDTH-bit adder sequencer reusing one external 4-bit CLA slice, LS nibble first.
// Optional signed-overflow output enabled by defining CLA_SEQ_OVF_EN.
module cla4_serial_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic [3:0]       cla_a,
    output logic [3:0]       cla_b,
    output logic             cla_ci,
    input  logic [3:0]       cla_s,
    input  logic             cla_co
`ifdef CLA_SEQ_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int STEPS = WIDTH / 4;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   a_reg, a_next;
    logic [WIDTH-1:0]   b_reg, b_next;
    logic [WIDTH-1:0]   s_reg, s_next;
    logic               carry_reg, carry_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [WIDTH-1:0]   a_shr, b_shr, s_shr;

    // Nibble-wide right shifts; the slice sum enters at the top of the sum register.
    genvar gi;
    generate
        for (gi = 0; gi < STEPS - 1; gi++) begin : g_shift
            assign a_shr[gi*4 +: 4] = a_reg[(gi+1)*4 +: 4];
            assign b_shr[gi*4 +: 4] = b_reg[(gi+1)*4 +: 4];
            assign s_shr[gi*4 +: 4] = s_reg[(gi+1)*4 +: 4];
        end
    endgenerate
    assign a_shr[WIDTH-1 -: 4] = 4'd0;
    assign b_shr[WIDTH-1 -: 4] = 4'd0;
    assign s_shr[WIDTH-1 -: 4] = cla_s;

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        s_next     = s_reg;
        carry_next = carry_reg;
        cnt_next   = cnt_reg;
        busy       = 1'b0;
        done       = 1'b0;
        cla_a      = 4'd0;
        cla_b      = 4'd0;
        cla_ci     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_next     = a;
                    b_next     = b;
                    carry_next = ci;
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy       = 1'b1;
                cla_a      = a_reg[3:0];
                cla_b      = b_reg[3:0];
                cla_ci     = carry_reg;
                a_next     = a_shr;
                b_next     = b_shr;
                s_next     = s_shr;
                carry_next = cla_co;
                cnt_next   = cnt_reg + 1'b1;
                if (cnt_reg == CNT_W'(STEPS - 1))
                    state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            s_reg     <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            s_reg     <= s_next;
            carry_reg <= carry_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign s  = s_reg;
    assign co = carry_reg;

`ifdef CLA_SEQ_OVF_EN
    logic sign_a_reg, sign_b_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
        end else if (state_reg == IDLE && start) begin
            sign_a_reg <= a[WIDTH-1];
            sign_b_reg <= b[WIDTH-1];
        end
    end

    assign ovf = (sign_a_reg == sign_b_reg) & (s_reg[WIDTH-1] != sign_a_reg);
`endif

endmodule

// File: tb/tb_cla4_serial_ctrl.sv
// Directed bench for cla4_serial_ctrl with a behavioural 4-bit slice; inputs driven and
// outputs sampled on the falling edge.
module tb_cla4_serial_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] a, b;
    logic        ci;
    logic        busy, done, co;
    logic [31:0] s;
    logic [3:0]  cla_a, cla_b, cla_s;
    logic        cla_ci, cla_co;
`ifdef CLA_SEQ_OVF_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign {cla_co, cla_s} = {1'b0, cla_a} + {1'b0, cla_b} + {4'd0, cla_ci};

    cla4_serial_ctrl #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .ci      (ci),
        .busy    (busy),
        .done    (done),
        .s       (s),
        .co      (co),
        .cla_a   (cla_a),
        .cla_b   (cla_b),
        .cla_ci  (cla_ci),
        .cla_s   (cla_s),
        .cla_co  (cla_co)
`ifdef CLA_SEQ_OVF_EN
        ,
        .ovf     (ovf)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Present a request for one cycle; returns in the first RUN cycle with inputs scrambled.
    task automatic do_start(input logic [31:0] av, input logic [31:0] bv, input logic civ);
        a = av; b = bv; ci = civ; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; ci = 1'b0;
    endtask

    // Count clock edges from the accepting edge until done, bounded.
    task automatic wait_done(output int edges);
        edges = 1;
        while (!done && edges < 30) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) n++;
        end
    endtask

    int          lat, n;
    logic [31:0] s_cap;
    logic [7:0]  ci_exp;

    initial begin
        reset_n = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0;

        // Async reset mid-cycle takes effect immediately.
        #13 reset_n = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_s",    64'(s),    64'd0);
        chk("rst_co",   64'(co),   64'd0);
        chk("rst_cla",  64'({cla_a, cla_b, cla_ci}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        a = 32'hDEADBEEF; b = 32'h12345678;
        count_dones(20, n);
        chk("idle_nodone", 64'(n), 64'd0);
        chk("idle_cla_a",  64'(cla_a), 64'd0);

        // 0xFFFFFFFF + 1: done after STEPS RUN edges (9th cycle from start edge).
        do_start(32'hFFFFFFFF, 32'h00000001, 1'b0);
        chk("run_busy", 64'(busy), 64'd1);
        wait_done(lat);
        chk("latency", 64'(lat), 64'd9);
        chk("ff_s",    64'(s),   64'h00000000);
        chk("ff_co",   64'(co),  64'd1);
        chk("done_busy", 64'(busy), 64'd1);
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'd0);
        chk("idle_busy",  64'(busy), 64'd0);
        repeat (4) @(negedge clk);
        chk("hold_s",  64'(s),  64'h00000000);
        chk("hold_co", 64'(co), 64'd1);

        // Carry chain: only nibble 0 sees a carry-in.
        ci_exp = 8'b0000_0001;
        do_start(32'h12345678, 32'h11111111, 1'b1);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("cla_ci_%0d", k), 64'(cla_ci), 64'(ci_exp[k]));
            @(negedge clk);
        end
        chk("seq_done", 64'(done), 64'd1);
        chk("seq_s",    64'(s),    64'h2345678A);
        chk("seq_co",   64'(co),   64'd0);

        // Second request during RUN is ignored and not queued.
        @(negedge clk);
        do_start(32'd1, 32'd1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        a = 32'd5; b = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0; s_cap = '0;
        for (int i = 0; i < 25; i++) begin
            if (done) begin n++; s_cap = s; end
            @(negedge clk);
        end
        chk("ign_ndone", 64'(n),     64'd1);
        chk("ign_s",     64'(s_cap), 64'h00000002);

        // Reset in RUN cycle 4 discards the partial result.
        do_start(32'hFFFFFFFF, 32'h00000001, 1'b0);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_s",    64'(s),    64'd0);
        chk("mid_co",   64'(co),   64'd0);
        chk("mid_cla",  64'({cla_a, cla_b, cla_ci}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        count_dones(15, n);
        chk("mid_nodone", 64'(n), 64'd0);
        do_start(32'd2, 32'd3, 1'b0);
        wait_done(lat);
        chk("post_lat", 64'(lat), 64'd9);
        chk("post_s",   64'(s),   64'd5);
        chk("post_co",  64'(co),  64'd0);

`ifdef CLA_SEQ_OVF_EN
        @(negedge clk);
        do_start(32'h7FFFFFFF, 32'h00000001, 1'b0);
        wait_done(lat);
        chk("ovf1_s",   64'(s),   64'h80000000);
        chk("ovf1_co",  64'(co),  64'd0);
        chk("ovf1_ovf", 64'(ovf), 64'd1);
        @(negedge clk);
        do_start(32'h80000000, 32'h80000000, 1'b0);
        wait_done(lat);
        chk("ovf2_s",   64'(s),   64'h00000000);
        chk("ovf2_co",  64'(co),  64'd1);
        chk("ovf2_ovf", 64'(ovf), 64'd1);
        repeat (3) @(negedge clk);
        chk("ovf2_hold", 64'(ovf), 64'd1);
        do_start(32'h00000005, 32'hFFFFFFFF, 1'b0);
        wait_done(lat);
        chk("ovf3_s",   64'(s),   64'h00000004);
        chk("ovf3_ovf", 64'(ovf), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
